// File: rtl/instr_fetch_if.sv
// Fetch-stage bus: local-store read port plus the decode-facing head entry.
//
// Handshake: the head entry {instr_out, pc_out} is offered while instr_valid=1.
// Decode accepts it in any cycle where instr_valid=1 and stall=0, unless
// branch_taken=1 in that cycle, in which case the head is wrong-path and is
// dropped rather than accepted. While stall=1 the head is held unchanged.
interface instr_fetch_if #(
    parameter int INSTR_W = 32,
    parameter int PC_W    = 8
);
    logic               ls_rd_en;
    logic [PC_W-1:0]    ls_addr;
    logic [INSTR_W-1:0] ls_data;
    logic               stall;
    logic               branch_taken;
    logic [PC_W-1:0]    pc_wb;
    logic [INSTR_W-1:0] instr_out;
    logic [PC_W-1:0]    pc_out;
    logic               instr_valid;

    // Fetch-stage side.
    modport master (
        output ls_rd_en, ls_addr, instr_out, pc_out, instr_valid,
        input  ls_data, stall, branch_taken, pc_wb
    );

    // Environment side: local store, decode and the branch unit.
    modport slave (
        input  ls_rd_en, ls_addr, instr_out, pc_out, instr_valid,
        output ls_data, stall, branch_taken, pc_wb
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage: holds the fetch PC, issues one-cycle-latency reads
// to the instruction local store, buffers returned words in a 2-entry queue
// and flushes all wrong-path state on a taken branch.
module instr_fetch #(
    parameter int LS_DEPTH = 256,
    parameter int INSTR_W  = 32
) (
    input logic           clk,
    input logic           reset,
    instr_fetch_if.master bus
);
    localparam int PC_W = $clog2(LS_DEPTH);

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0] fetch_pc;
    logic            req_v;
    logic [PC_W-1:0] req_pc;
    entry_t          fifo_q [2];
    logic [1:0]      count;

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] occ;
    entry_t     push_entry;

    // Occupancy counts buffered words plus the read still in flight, so the
    // issue rule alone guarantees the queue can never overflow.
    assign occ        = count + {1'b0, req_v};
    assign pop        = bus.instr_valid & ~bus.stall & ~bus.branch_taken;
    assign push       = req_v;
    assign issue      = reset & ~bus.branch_taken &
                        ((occ < 2'd2) | ((occ == 2'd2) & pop));
    assign push_entry = {req_pc, bus.ls_data};

    assign bus.ls_rd_en    = issue;
    assign bus.ls_addr     = fetch_pc;
    assign bus.instr_valid = (count != 2'd0);
    assign bus.instr_out   = bus.instr_valid ? fifo_q[0].instr : '0;
    assign bus.pc_out      = bus.instr_valid ? fifo_q[0].pc    : '0;

    // Fetch PC and in-flight request tag; reset beats redirect, redirect beats issue.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc <= '0;
            req_v    <= 1'b0;
            req_pc   <= '0;
        end else if (bus.branch_taken) begin
            fetch_pc <= bus.pc_wb;
            req_v    <= 1'b0;
        end else begin
            req_v <= issue;
            if (issue) begin
                req_pc   <= fetch_pc;
                fetch_pc <= fetch_pc + 1'b1;
            end
        end
    end

    // Queue occupancy; a flush empties it regardless of push, pop or stall.
    always_ff @(posedge clk) begin
        if (!reset || bus.branch_taken) begin
            count <= 2'd0;
        end else begin
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    // Queue storage as a 2-deep shift register with the head in slot 0;
    // contents past count are don't-care so the data needs no reset.
    always_ff @(posedge clk) begin
        case ({push, pop})
            2'b10: fifo_q[count[0]] <= push_entry;
            2'b01: fifo_q[0] <= fifo_q[1];
            2'b11: begin
                if (count == 2'd1) begin
                    fifo_q[0] <= push_entry;
                end else begin
                    fifo_q[0] <= fifo_q[1];
                    fifo_q[1] <= push_entry;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios followed by a random phase, with
// a stream-level reference model checked every cycle.
module tb_instr_fetch;
    logic clk = 1'b0;
    logic reset;

    // Clock.
    always #5 clk = ~clk;

    instr_fetch_if #(.INSTR_W(32), .PC_W(8)) bus ();

    instr_fetch #(.LS_DEPTH(256), .INSTR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Local store contents: word i holds 32'h1000_0000 + i.
    function automatic logic [31:0] ls_word(input logic [7:0] a);
        return 32'h1000_0000 + {24'h0, a};
    endfunction

    // Local store with one-cycle read latency.
    always @(posedge clk) begin
        if (bus.ls_rd_en) bus.ls_data <= ls_word(bus.ls_addr);
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the decode side must see the instruction stream
    // next_pc, next_pc+1, ... restarting at 0 on reset and at pc_wb on a
    // branch; outstanding = fetched-but-not-consumed words since the last flush.
    logic        armed       = 1'b0;
    logic [7:0]  next_pc     = 8'h00;
    int          outstanding = 0;
    int          since_flush = 0;
    logic        prev_hold   = 1'b0;
    logic [7:0]  prev_pc     = 8'h00;
    logic [31:0] prev_instr  = 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: check the current cycle mid-period, advance the model
    // across the edge, then return just after the edge.
    task automatic tick();
        logic       consumed;
        logic       exp_issue;
        logic [7:0] exp_addr;
        @(negedge clk);
        consumed = 1'b0;
        if (armed) begin
            if (!bus.instr_valid) begin
                chk("empty_instr", bus.instr_out, 32'h0);
                chk("empty_pc", 32'(bus.pc_out), 32'h0);
            end else begin
                chk("head_pc", 32'(bus.pc_out), 32'(next_pc));
                chk("head_instr", bus.instr_out, ls_word(bus.pc_out));
            end
            if (prev_hold) begin
                chk("hold_valid", 32'(bus.instr_valid), 32'h1);
                chk("hold_pc", 32'(bus.pc_out), 32'(prev_pc));
                chk("hold_instr", bus.instr_out, prev_instr);
            end
            if (since_flush == 1 || since_flush == 2)
                chk("bubble_valid", 32'(bus.instr_valid), 32'h0);
            else if (since_flush >= 3)
                chk("stream_valid", 32'(bus.instr_valid), 32'h1);
            if (!reset) begin
                chk("rd_en_in_reset", 32'(bus.ls_rd_en), 32'h0);
            end else if (bus.branch_taken) begin
                chk("rd_en_on_branch", 32'(bus.ls_rd_en), 32'h0);
            end else begin
                consumed  = bus.instr_valid & ~bus.stall;
                exp_issue = (outstanding - int'(consumed)) < 2;
                chk("rd_en", 32'(bus.ls_rd_en), 32'(exp_issue));
                if (bus.ls_rd_en) begin
                    exp_addr = next_pc + 8'(outstanding);
                    chk("ls_addr", 32'(bus.ls_addr), 32'(exp_addr));
                end
            end
        end
        // Model update for the coming edge.
        if (!reset || bus.branch_taken) begin
            next_pc     = reset ? bus.pc_wb : 8'h00;
            outstanding = 0;
            since_flush = 1;
            prev_hold   = 1'b0;
            armed       = 1'b1;
        end else if (armed) begin
            outstanding = outstanding - int'(consumed) + int'(bus.ls_rd_en);
            chk("occ_bound", 32'(outstanding <= 2), 32'h1);
            if (consumed) next_pc = next_pc + 8'h01;
            prev_hold  = bus.instr_valid & bus.stall;
            prev_pc    = bus.pc_out;
            prev_instr = bus.instr_out;
            if (since_flush < 3) since_flush++;
        end
        @(posedge clk);
        #1;
    endtask

    // Directed steps, then random stimulus, then the report.
    initial begin
        int n;
        reset            = 1'b0;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        bus.pc_wb        = 8'h00;

        // Reset for two cycles.
        tick();
        chk("rst_valid", 32'(bus.instr_valid), 32'h0);
        chk("rst_instr", bus.instr_out, 32'h0);
        chk("rst_pc", 32'(bus.pc_out), 32'h0);
        chk("rst_addr", 32'(bus.ls_addr), 32'h0);
        tick();

        // 1: release reset, cycle R.
        reset = 1'b1;
        #1;
        chk("t1_R_rd_en", 32'(bus.ls_rd_en), 32'h1);
        chk("t1_R_addr", 32'(bus.ls_addr), 32'h0);
        tick();
        chk("t1_R1_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("t1_R2_valid", 32'(bus.instr_valid), 32'h1);
        chk("t1_R2_pc", 32'(bus.pc_out), 32'h0);
        chk("t1_R2_instr", bus.instr_out, 32'h1000_0000);
        tick();
        chk("t1_pc1", 32'(bus.pc_out), 32'h1);
        tick();
        chk("t1_pc2", 32'(bus.pc_out), 32'h2);
        tick();
        chk("t1_pc3", 32'(bus.pc_out), 32'h3);

        // 2: stall for 3 cycles while pc_out=05.
        n = 0;
        while (bus.pc_out != 8'h05 && n < 10) begin
            tick();
            n++;
        end
        chk("t2_reach_05", 32'(bus.pc_out), 32'h5);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t2_stall_pc", 32'(bus.pc_out), 32'h5);
            chk("t2_stall_instr", bus.instr_out, 32'h1000_0005);
            chk("t2_stall_rd_en", 32'(bus.ls_rd_en), 32'h0);
            tick();
        end
        bus.stall = 1'b0;
        #1;
        chk("t2_rel_pc5", 32'(bus.pc_out), 32'h5);
        tick();
        chk("t2_rel_pc6", 32'(bus.pc_out), 32'h6);
        tick();
        chk("t2_rel_pc7", 32'(bus.pc_out), 32'h7);

        // 3: branch to 8'h40 in cycle N.
        bus.branch_taken = 1'b1;
        bus.pc_wb        = 8'h40;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        chk("t3_N1_valid", 32'(bus.instr_valid), 32'h0);
        chk("t3_N1_addr", 32'(bus.ls_addr), 32'h40);
        chk("t3_N1_rd_en", 32'(bus.ls_rd_en), 32'h1);
        tick();
        chk("t3_N2_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("t3_N3_pc", 32'(bus.pc_out), 32'h40);
        chk("t3_N3_instr", bus.instr_out, 32'h1000_0040);
        tick();
        chk("t3_N4_pc", 32'(bus.pc_out), 32'h41);

        // 4: same branch while stalled with a full queue.
        bus.stall = 1'b1;
        tick();
        tick();
        bus.branch_taken = 1'b1;
        bus.pc_wb        = 8'h40;
        tick();
        bus.branch_taken = 1'b0;
        #1;
        chk("t4_N1_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("t4_N2_valid", 32'(bus.instr_valid), 32'h0);
        tick();
        chk("t4_N3_pc", 32'(bus.pc_out), 32'h40);
        bus.stall = 1'b0;
        tick();
        chk("t4_next_pc", 32'(bus.pc_out), 32'h41);
        tick();
        chk("t4_next_pc2", 32'(bus.pc_out), 32'h42);

        // 5: branch to 8'hFE, wrap-around.
        bus.branch_taken = 1'b1;
        bus.pc_wb        = 8'hFE;
        tick();
        bus.branch_taken = 1'b0;
        tick();
        tick();
        chk("t5_pc_fe", 32'(bus.pc_out), 32'hFE);
        tick();
        chk("t5_pc_ff", 32'(bus.pc_out), 32'hFF);
        tick();
        chk("t5_pc_00", 32'(bus.pc_out), 32'h00);
        tick();
        chk("t5_pc_01", 32'(bus.pc_out), 32'h01);

        // 6: one reset cycle together with a branch.
        reset            = 1'b0;
        bus.branch_taken = 1'b1;
        bus.pc_wb        = 8'h80;
        #1;
        chk("t6_rst_rd_en", 32'(bus.ls_rd_en), 32'h0);
        tick();
        reset            = 1'b1;
        bus.branch_taken = 1'b0;
        #1;
        chk("t6_R_valid", 32'(bus.instr_valid), 32'h0);
        chk("t6_R_addr", 32'(bus.ls_addr), 32'h0);
        tick();
        tick();
        chk("t6_R2_valid", 32'(bus.instr_valid), 32'h1);
        chk("t6_R2_pc", 32'(bus.pc_out), 32'h0);

        // Random phase: stalls, branches and occasional resets.
        for (int i = 0; i < 400; i++) begin
            bus.stall        = ($urandom_range(0, 3) == 0);
            bus.branch_taken = ($urandom_range(0, 19) == 0);
            bus.pc_wb        = 8'($urandom_range(0, 255));
            reset            = ($urandom_range(0, 49) != 0);
            tick();
        end

        // Drain with a clean stream.
        reset            = 1'b1;
        bus.stall        = 1'b0;
        bus.branch_taken = 1'b0;
        for (int i = 0; i < 8; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
